// File: rtl/unsaved_debug_mem_pkg.sv
// Shared types and constants for the debug-memory bridge.
// The jdo bit positions match the debug slave's command layout.
package unsaved_debug_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int DATA_W          = 32;
  localparam int JDO_W           = 38;
  localparam int JDO_ADDR_LSB    = 26;
  localparam int JDO_ADDR_MSB    = 33;
  localparam int JDO_READ_NOW    = 34;
  localparam int JDO_CLR_ERR     = 35;
  localparam int JDO_WDATA_LSB   = 3;
  localparam int JDO_WDATA_MSB   = 34;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/unsaved_nios2_gen2_0_cpu_debug_mem_bridge_timeout.sv
// Stall counter for one memory access; flags the stall that reaches TIMEOUT.
// Instantiated only when UNSAVED_DEBUG_MEM_TIMEOUT_EN is defined.
module unsaved_debug_mem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  logic [7:0] cnt;

  // Fires on the stall that would bring the count up to TIMEOUT.
  assign terminal = en && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || terminal) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/unsaved_nios2_gen2_0_cpu_debug_mem_bridge.sv
// Sysclk-side executor of decoded JTAG debug-memory commands: one word per
// command. Optional access timeout: define UNSAVED_DEBUG_MEM_TIMEOUT_EN.
module unsaved_nios2_gen2_0_cpu_debug_mem_bridge
  import unsaved_debug_mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest
);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   mon_a, mon_a_nxt;
  logic [DATA_W-1:0]   mon_d, mon_d_nxt;
  logic [DATA_W-1:0]   wdata, wdata_nxt;
  logic                no_inc, no_inc_nxt;
  logic                err, err_nxt;
  logic                err_set, err_clr;
  logic                ready;
  logic                busy, stall, any_strobe, tmo_hit;
  logic                unused_jdo;

  assign busy       = (state != ST_IDLE);
  assign stall      = busy && mem_waitrequest;
  assign any_strobe = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_CLR_ERR+1], jdo[JDO_WDATA_LSB-1:0]};

`ifdef UNSAVED_DEBUG_MEM_TIMEOUT_EN
  unsaved_debug_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (!busy),
    .en       (stall),
    .terminal (tmo_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^8'(TIMEOUT);
  assign tmo_hit    = 1'b0;
`endif

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    mon_a_nxt  = mon_a;
    mon_d_nxt  = mon_d;
    wdata_nxt  = wdata;
    no_inc_nxt = no_inc;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_nxt = ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
          err_clr   = jdo[JDO_CLR_ERR];
          if (jdo[JDO_READ_NOW]) begin
            state_nxt  = ST_READ;
            no_inc_nxt = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_nxt = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          state_nxt = ST_WRITE;
        end else if (take_no_action_ocimem_a) begin
          state_nxt  = ST_READ;
          no_inc_nxt = 1'b0;
        end
      end
      default: begin
        // Commands arriving mid-access are dropped but flagged as overrun.
        err_set = any_strobe;
        if (!mem_waitrequest) begin
          if (state == ST_READ) begin
            mon_d_nxt = mem_readdata;
            if (!no_inc) mon_a_nxt = mon_a + ADDR_W'(1);
          end else begin
            mon_a_nxt = mon_a + ADDR_W'(1);
          end
          state_nxt = ST_IDLE;
        end else if (tmo_hit) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
    // A set in the same cycle as a clear must leave the flag raised.
    if (err_set)      err_nxt = 1'b1;
    else if (err_clr) err_nxt = 1'b0;
    else              err_nxt = err;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      mon_a  <= '0;
      mon_d  <= '0;
      wdata  <= '0;
      no_inc <= 1'b0;
      err    <= 1'b0;
      ready  <= 1'b1;
    end else begin
      state  <= state_nxt;
      mon_a  <= mon_a_nxt;
      mon_d  <= mon_d_nxt;
      wdata  <= wdata_nxt;
      no_inc <= no_inc_nxt;
      err    <= err_nxt;
      ready  <= (state_nxt == ST_IDLE);
    end
  end

  assign MonDReg       = mon_d;
  assign monitor_ready = ready;
  assign monitor_error = err;
  assign mem_address   = mon_a;
  assign mem_read      = (state == ST_READ);
  assign mem_write     = (state == ST_WRITE);
  assign mem_writedata = wdata;

endmodule

// File: tb/tb_unsaved_nios2_gen2_0_cpu_debug_mem_bridge.sv
// Bench for the debug-memory bridge: directed cases plus random commands
// against a word-level model of the memory, address and status registers.
module tb_unsaved_nios2_gen2_0_cpu_debug_mem_bridge;

  localparam int TMO       = 4;
  localparam int K_ADDR    = 0;
  localparam int K_ADDR_RD = 1;
  localparam int K_WRITE   = 2;
  localparam int K_READ    = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_waitrequest;

  unsaved_nios2_gen2_0_cpu_debug_mem_bridge #(
    .ADDR_W  (8),
    .TIMEOUT (TMO)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_readdata            (mem_readdata),
    .mem_waitrequest         (mem_waitrequest)
  );

  initial forever #5 clk = ~clk;

  // Memory slave: stalls the first wait_cfg cycles of each request, or forever when stuck.
  logic [31:0] slave_mem [256];
  int          req_cycles = 0;
  int          wait_cfg = 0;
  bit          stuck = 1'b0;

  always_comb mem_waitrequest = (mem_read || mem_write) && (stuck || (req_cycles < wait_cfg));
  always_comb mem_readdata    = slave_mem[mem_address];

  always @(posedge clk) begin
    if ((mem_read || mem_write) && mem_waitrequest) req_cycles <= req_cycles + 1;
    else                                            req_cycles <= 0;
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  logic [7:0]  exp_a;
  logic [31:0] exp_d;
  logic        exp_err;
  int          n_vec, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dreg"}, MonDReg, exp_d);
    check({tag, "_areg"}, mem_address, exp_a);
    check({tag, "_err"}, monitor_error, exp_err);
    check({tag, "_idle"}, {monitor_ready, mem_read, mem_write}, 3'b100);
  endtask

  // One command from the debug slave; ov != 0 fires a second strobe mid-access.
  task automatic run_cmd(input int kind, input logic [7:0] addr, input logic [31:0] data,
                         input bit clr, input int waits, input int ov);
    logic [7:0] acc_a;
    int         low;
    wait_cfg = waits;
    @(negedge clk);
    if (kind == K_WRITE) begin
      jdo = {3'($urandom), data, 3'($urandom)};
      take_action_ocimem_b = 1'b1;
    end else if (kind == K_READ) begin
      jdo = 38'($urandom);
      take_no_action_ocimem_a = 1'b1;
    end else begin
      jdo = {2'($urandom), clr, (kind == K_ADDR_RD), addr, 26'($urandom)};
      take_action_ocimem_a = 1'b1;
    end
    @(negedge clk);
    clear_strobes();
    if (kind == K_ADDR || kind == K_ADDR_RD) begin
      exp_a = addr;
      if (clr) exp_err = 1'b0;
    end
    if (kind == K_ADDR) begin
      check_idle("addr_load");
      return;
    end
    acc_a = exp_a;
    check("req_ready_low", monitor_ready, 0);
    check("req_kind", {mem_write, mem_read}, (kind == K_WRITE) ? 2'b10 : 2'b01);
    check("req_addr", mem_address, acc_a);
    if (kind == K_WRITE) check("req_wdata", mem_writedata, data);
    if (ov != 0 && waits > 0) begin
      jdo = {6'($urandom), 32'($urandom)};
      take_action_ocimem_a    = (ov == 1);
      take_action_ocimem_b    = (ov == 2);
      take_no_action_ocimem_a = (ov == 3);
      exp_err = 1'b1;
    end
    low = 0;
    while (monitor_ready !== 1'b1 && low < 50) begin
      if (mem_write === 1'b1 && mem_waitrequest === 1'b0) slave_mem[mem_address] = mem_writedata;
      low++;
      @(negedge clk);
      clear_strobes();
    end
    check("busy_cycles", low, waits + 1);
    if (kind == K_WRITE) begin
      ref_mem[acc_a] = data;
      exp_a = acc_a + 8'd1;
    end else begin
      exp_d = ref_mem[acc_a];
      if (kind == K_READ) exp_a = acc_a + 8'd1;
    end
    check_idle("done");
  endtask

  initial begin
    int kind, waits, ov;
    int low;
    n_vec = 0;
    n_err = 0;
    jdo = '0;
    clear_strobes();
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    exp_a = 8'h00;
    exp_d = 32'h0;
    exp_err = 1'b0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_wdata", mem_writedata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Read-now at 0x10, no wait states.
    ref_mem[16]   = 32'hDEADBEEF;
    slave_mem[16] = 32'hDEADBEEF;
    run_cmd(K_ADDR_RD, 8'h10, 32'h0, 1'b0, 0, 0);
    check("readnow_value", MonDReg, 32'hDEADBEEF);
    check("readnow_addr", mem_address, 8'h10);

    // Write at 0xFF with 3 wait states wraps the address to 0x00.
    run_cmd(K_ADDR, 8'hFF, 32'h0, 1'b0, 0, 0);
    run_cmd(K_WRITE, 8'h00, 32'h12345678, 1'b0, 3, 0);
    check("wrap_addr", mem_address, 8'h00);
    run_cmd(K_ADDR_RD, 8'hFF, 32'h0, 1'b0, 0, 0);
    check("wrap_readback", MonDReg, 32'h12345678);

    // Overrun while a read stalls, then cleared.
    run_cmd(K_READ, 8'h00, 32'h0, 1'b0, 2, 3);
    check("overrun_err", monitor_error, 1);
    run_cmd(K_ADDR, 8'h20, 32'h0, 1'b1, 0, 0);
    check("overrun_clear", monitor_error, 0);

    // Address load and write strobe together: only the load happens.
    @(negedge clk);
    jdo = {2'b00, 1'b0, 1'b0, 8'h5A, 26'h0};
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    clear_strobes();
    exp_a = 8'h5A;
    check_idle("a_b_same_cycle");
    @(negedge clk);
    check("a_b_no_write", mem_write, 0);

    // Memory stuck in waitrequest.
    wait_cfg = 0;
    stuck = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    clear_strobes();
`ifdef UNSAVED_DEBUG_MEM_TIMEOUT_EN
    low = 0;
    while (mem_read === 1'b1 && low < 20) begin
      low++;
      @(negedge clk);
    end
    check("timeout_cycles", low, TMO);
    exp_err = 1'b1;
    check_idle("timeout");
    stuck = 1'b0;
`else
    repeat (40) @(negedge clk);
    check("stall_held", {mem_read, monitor_ready}, 2'b10);
    stuck = 1'b0;
    @(negedge clk);
    exp_d = ref_mem[exp_a];
    exp_a = exp_a + 8'd1;
    check_idle("stall_release");
`endif
    run_cmd(K_ADDR, 8'h33, 32'h0, 1'b1, 0, 0);

    // Reset in the middle of a stalled write.
    stuck = 1'b1;
    @(negedge clk);
    jdo = {3'b000, 32'hCAFEF00D, 3'b000};
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    clear_strobes();
    check("rst_pre_write", mem_write, 1);
    #2 reset_n = 1'b0;
    #1;
    exp_a = 8'h00;
    exp_d = 32'h0;
    exp_err = 1'b0;
    check_idle("async_reset");
    check("async_reset_wdata", mem_writedata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stuck = 1'b0;

    // Random command mix with random stalls and overruns.
    for (int i = 0; i < 60; i++) begin
      kind  = $urandom_range(0, 3);
      waits = $urandom_range(0, 3);
      ov    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_cmd(kind, 8'($urandom), $urandom, 1'($urandom), waits, ov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
